// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Purpose  : Shared widths, field positions and FSM encoding for the FP
//            operand alignment stage.
// Revision : 1.0
// ============================================================================
package fp_pkg;

    localparam int FRAC_W    = 27;
    localparam int EXP_W     = 8;
    localparam int MAX_SHIFT = 27;
    localparam int CNT_W     = $clog2(MAX_SHIFT + 1);

    // IEEE-754 single field positions
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_MSB  = 22;

    // Aligned fraction layout: hidden, 23 fraction bits, guard, round, sticky
    localparam int HIDDEN_BIT = 26;
    localparam int GUARD_BIT  = 2;
    localparam int ROUND_BIT  = 1;
    localparam int STICKY_BIT = 0;

    localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UNPACK = 2'd1,
        SHIFT  = 2'd2,
        DONE   = 2'd3
    } align_state_t;

endpackage : fp_pkg
`default_nettype wire

// File: rtl/fp_unpack.sv
`default_nettype none
// ============================================================================
// Module   : fp_unpack
// Purpose  : Combinational split of one IEEE-754 single into sign, effective
//            exponent, 27-bit GRS-extended fraction and special flag.
// Revision : 1.0
// ============================================================================
module fp_unpack
    import fp_pkg::*;
(
    input  logic [31:0]       i_op,
    output logic              o_sign,
    output logic [EXP_W-1:0]  o_eff_exp,
    output logic [FRAC_W-1:0] o_frac,
    output logic              o_is_special
);

    logic [EXP_W-1:0] w_exp;
    logic             w_zero_exp;

    assign w_exp      = i_op[EXP_MSB:EXP_LSB];
    assign w_zero_exp = (w_exp == '0);

    // Zeros and denormals share effective exponent 1 with no hidden bit
    assign o_sign       = i_op[SIGN_BIT];
    assign o_eff_exp    = w_zero_exp ? EXP_W'(1) : w_exp;
    assign o_frac       = {~w_zero_exp, i_op[MAN_MSB:0], 3'b000};
    assign o_is_special = (w_exp == EXP_SPECIAL);

endmodule : fp_unpack
`default_nettype wire

// File: rtl/fp_align_unit.sv
`default_nettype none
// ============================================================================
// Module   : fp_align_unit
// Purpose  : FP adder operand stage: unpack, swap by exponent and align the
//            smaller fraction with a one-bit-per-cycle sticky shifter.
// Revision : 1.0
// ============================================================================
module fp_align_unit
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       op_a,
    input  logic [31:0]       op_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FRAC_W-1:0] big_frac,
    output logic [FRAC_W-1:0] small_frac,
    output logic [EXP_W-1:0]  exp_out,
    output logic [EXP_W-1:0]  exp_diff,
    output logic              sign_big,
    output logic              sign_small,
    output logic              big_is_b,
    output logic              special
);

    align_state_t r_state;
    align_state_t w_state_nxt;

    logic [31:0]      r_op_a;
    logic [31:0]      r_op_b;
    logic [CNT_W-1:0] r_cnt;

    logic              w_sign_a, w_sign_b;
    logic [EXP_W-1:0]  w_exp_a, w_exp_b;
    logic [FRAC_W-1:0] w_frac_a, w_frac_b;
    logic              w_spec_a, w_spec_b;

    logic              w_b_big;
    logic              w_special;
    logic [EXP_W:0]    w_diff_full;
    logic [EXP_W-1:0]  w_diff_sat;
    logic [EXP_W-1:0]  w_abs_diff;
    logic [CNT_W-1:0]  w_shift_n;

    fp_unpack u_unpack_a (
        .i_op         (r_op_a),
        .o_sign       (w_sign_a),
        .o_eff_exp    (w_exp_a),
        .o_frac       (w_frac_a),
        .o_is_special (w_spec_a)
    );

    fp_unpack u_unpack_b (
        .i_op         (r_op_b),
        .o_sign       (w_sign_b),
        .o_eff_exp    (w_exp_b),
        .o_frac       (w_frac_b),
        .o_is_special (w_spec_b)
    );

    assign w_b_big     = (w_exp_b > w_exp_a);
    assign w_special   = w_spec_a | w_spec_b;
    assign w_diff_full = {1'b0, w_exp_a} - {1'b0, w_exp_b};

    // The 9-bit difference fits in 8 signed bits only when its top two bits agree
    assign w_diff_sat = (w_diff_full[EXP_W] != w_diff_full[EXP_W-1])
                      ? (w_diff_full[EXP_W] ? 8'h80 : 8'h7F)
                      : w_diff_full[EXP_W-1:0];

    assign w_abs_diff = w_b_big ? (w_exp_b - w_exp_a) : (w_exp_a - w_exp_b);
    assign w_shift_n  = (w_abs_diff > EXP_W'(MAX_SHIFT)) ? CNT_W'(MAX_SHIFT)
                                                         : w_abs_diff[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid) begin
                    w_state_nxt = UNPACK;
                end
            end
            UNPACK: begin
                if (w_special || (w_shift_n == '0)) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Result registers are written only while computing, so they hold through DONE and IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_cnt      <= '0;
            big_frac   <= '0;
            small_frac <= '0;
            exp_out    <= '0;
            exp_diff   <= '0;
            sign_big   <= 1'b0;
            sign_small <= 1'b0;
            big_is_b   <= 1'b0;
            special    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op_a <= op_a;
                        r_op_b <= op_b;
                    end
                end
                UNPACK: begin
                    big_frac   <= w_b_big ? w_frac_b : w_frac_a;
                    small_frac <= w_b_big ? w_frac_a : w_frac_b;
                    exp_out    <= w_b_big ? w_exp_b  : w_exp_a;
                    sign_big   <= w_b_big ? w_sign_b : w_sign_a;
                    sign_small <= w_b_big ? w_sign_a : w_sign_b;
                    big_is_b   <= w_b_big;
                    exp_diff   <= w_diff_sat;
                    special    <= w_special;
                    r_cnt      <= w_shift_n;
                end
                SHIFT: begin
                    small_frac <= {1'b0, small_frac[FRAC_W-1:2],
                                   small_frac[ROUND_BIT] | small_frac[STICKY_BIT]};
                    r_cnt      <= r_cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule : fp_align_unit
`default_nettype wire

// File: tb/tb_fp_align_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_align_unit
// Purpose  : Randomized scoreboard bench for fp_align_unit against an
//            arithmetic reference model.
// Revision : 1.0
// ============================================================================
module tb_fp_align_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [26:0] big_frac, small_frac;
    logic [7:0]  exp_out, exp_diff;
    logic        sign_big, sign_small, big_is_b, special;

    fp_align_unit dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .big_frac   (big_frac),
        .small_frac (small_frac),
        .exp_out    (exp_out),
        .exp_diff   (exp_diff),
        .sign_big   (sign_big),
        .sign_small (sign_small),
        .big_is_b   (big_is_b),
        .special    (special)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [26:0] bf, sf;
        logic [7:0]  e, d;
        logic        sb, ss, bib, sp;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    bit   have_cur = 0;
    bit   hold_ready = 0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string nm, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: value semantics of IEEE unpack + sticky right shift by min(|de|,27)
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int acc);
        exp_t   r;
        int     xa, xb, ea, eb, n, d;
        longint fa, fb, sml, res, mask;
        bit     spec, bbig;
        xa = int'(a[30:23]);
        xb = int'(b[30:23]);
        ea = (xa == 0) ? 1 : xa;
        eb = (xb == 0) ? 1 : xb;
        fa = ((xa == 0) ? 0 : 64'h800000) + longint'(a[22:0]);
        fb = ((xb == 0) ? 0 : 64'h800000) + longint'(b[22:0]);
        fa = fa * 8;
        fb = fb * 8;
        spec = (xa == 255) || (xb == 255);
        bbig = eb > ea;
        n = bbig ? eb - ea : ea - eb;
        if (n > 27) n = 27;
        if (spec) n = 0;
        sml  = bbig ? fa : fb;
        mask = (64'd1 << (n + 1)) - 1;
        res  = sml >> n;
        if ((sml & mask) != 0) res = res | 1;
        d = ea - eb;
        if (d > 127) d = 127;
        if (d < -128) d = -128;
        r.bf  = 27'(bbig ? fb : fa);
        r.sf  = 27'(res);
        r.e   = 8'(bbig ? eb : ea);
        r.d   = 8'(d);
        r.sb  = bbig ? b[31] : a[31];
        r.ss  = bbig ? a[31] : b[31];
        r.bib = bbig;
        r.sp  = spec;
        r.lat = 2 + n;
        r.acc = acc;
        return r;
    endfunction

    // Monitor: first DONE cycle is compared against the scoreboard, later ones for stability
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (!have_cur) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    cur = sb_q.pop_front();
                    have_cur = 1;
                    chk("latency", cyc - cur.acc, cur.lat);
                    chk("big_frac", big_frac, cur.bf);
                    chk("small_frac", small_frac, cur.sf);
                    chk("exp_out", exp_out, cur.e);
                    chk("exp_diff", exp_diff, cur.d);
                    chk("sign_big", sign_big, cur.sb);
                    chk("sign_small", sign_small, cur.ss);
                    chk("big_is_b", big_is_b, cur.bib);
                    chk("special", special, cur.sp);
                end
            end else begin
                chk("hold_stable", {big_frac, small_frac, exp_out, exp_diff,
                                    sign_big, sign_small, big_is_b, special},
                                   {cur.bf, cur.sf, cur.e, cur.d,
                                    cur.sb, cur.ss, cur.bib, cur.sp});
            end
            chk("in_ready_in_done", in_ready, 0);
            if (out_ready) have_cur = 0;
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 0, 1);
        end else begin
            in_valid = 1'b1;
            op_a = a;
            op_b = b;
            sb_q.push_back(model(a, b, cyc));
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((sb_q.size() != 0 || have_cur) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk("drain_timeout", sb_q.size(), 0);
    endtask

    task automatic chk_zero_outputs(input string nm);
        chk(nm, {out_valid, big_frac, small_frac, exp_out, exp_diff,
                 sign_big, sign_small, big_is_b, special}, 0);
    endtask

    logic [31:0] ra, rb;
    logic [7:0]  ex;

    initial begin
        repeat (3) begin
            @(negedge clk);
            chk("in_ready_during_rst", in_ready, 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);
        chk_zero_outputs("reset_outputs");

        issue(32'h3F800000, 32'h3F800000);
        issue(32'h3F800000, 32'h40000000);
        issue(32'h4B800000, 32'h3F800001);
        issue(32'h7F000000, 32'h3F800000);
        issue(32'h7F800000, 32'h3F800000);
        issue(32'h00000001, 32'h80400000);
        issue(32'h00000000, 32'h7F7FFFFF);
        drain();

        for (int i = 0; i < 80; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 4))
                0: begin
                    ex = ra[30:23] + 8'($urandom_range(0, 30));
                    rb[30:23] = ex;
                end
                1: rb[30:23] = ra[30:23];
                2: ra[30:23] = 8'($urandom_range(0, 1));
                3: rb[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
                default: ;
            endcase
            issue(ra, rb);
        end
        drain();

        // Back-pressure: keep the consumer stalled well beyond the result arrival
        hold_ready = 1;
        issue(32'hC1200000, 32'h3E000003);
        for (int w = 0; w < 100 && !out_valid; w++) @(negedge clk);
        repeat (5) @(negedge clk);
        hold_ready = 0;
        drain();

        // Reset in the middle of a long alignment
        issue(32'h7F000000, 32'h3F800000);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("in_ready_rst_mid_shift", in_ready, 0);
        @(posedge clk);
        #1;
        sb_q.delete();
        have_cur = 0;
        chk_zero_outputs("outputs_after_mid_rst");
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_mid_rst", in_ready, 1);
        chk_zero_outputs("idle_outputs_after_mid_rst");

        issue(32'h3F800000, 32'h40000000);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fp_align_unit
`default_nettype wire

// File: doc/fp_align_unit.md
# fp_align_unit

Upstream operand stage of the floating-point adder. Accepts two IEEE-754 single-precision operands over a valid/ready handshake and unpacks them into sign, effective exponent and 27-bit fraction (hidden, 23 fraction bits, guard, round, sticky). It selects the larger-exponent operand and aligns the smaller fraction with an iterative one-bit-per-cycle right shifter that accumulates sticky. It then presents both aligned fractions, the common exponent and the signed exponent difference to the add/normalize control and datapath.

## Interface
- `FRAC_W`, 27: aligned fraction width; `[26]` hidden, `[25:3]` fraction, `[2]` guard, `[1]` round, `[0]` sticky.
- `EXP_W`, 8: exponent width.
- `MAX_SHIFT`, 27: shift-count cap; beyond this, all bits are in sticky.

- `clk` in 1: the only clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operands present.
- `in_ready` out 1: block can accept operands.
- `op_a` in 32: IEEE-754 single operand A.
- `op_b` in 32: IEEE-754 single operand B.
- `out_valid` out 1: aligned result present.
- `out_ready` in 1: consumer accepts result.
- `big_frac` out 27: fraction of the larger-exponent operand, unshifted.
- `small_frac` out 27: fraction of the other operand, right-aligned, sticky in bit 0.
- `exp_out` out 8: effective exponent of the larger operand.
- `exp_diff` out 8: two's-complement effective exp(A) − exp(B), saturated to −128..127.
- `sign_big` out 1: sign of the big operand.
- `sign_small` out 1: sign of the small operand.
- `big_is_b` out 1: 1 when B is the big operand.
- `special` out 1: either operand has exponent 255 (Inf/NaN).

## Operation
- Unpack: exponent 0 → hidden bit 0, effective exponent 1 (zero and denormal); otherwise hidden bit 1, effective exponent = field. Fraction = {hidden, frac[22:0], 3'b000}.
- Swap: if eff_exp(B) > eff_exp(A), B is big and `big_is_b`=1; ties keep A as big (no fraction compare).
- Shift count n = min(|eff_exp(A) − eff_exp(B)|, 27).
- Each shift: small_frac ← {0, small_frac[26:1]}, with new bit 0 = old bit 1 | old bit 0.
- Special: if either exponent is 255, `special`=1 and no shifting. Fractions and exponents are presented as unpacked with the swap rule applied; the consumer handles the result.
- FSM states:
  - IDLE: `in_ready`=1. On `in_valid`, capture `op_a` and `op_b` and go to UNPACK.
  - UNPACK: compute fields, swap, n and `exp_diff`. Go to DONE if `special` or n=0, else SHIFT.
  - SHIFT: one shift per cycle with count decrement; go to DONE when the count reaches 0.
  - DONE: `out_valid`=1 with outputs stable. On `out_ready`, go to IDLE.
- `in_ready`=0 in UNPACK, SHIFT and DONE; no new operands are accepted until the result is consumed.
- Output registers change only in UNPACK and SHIFT; they hold their values through DONE and IDLE until the next UNPACK.

## Timing
- Reset: state=IDLE. `in_ready`=1 on the first cycle after `rst` is deasserted; while `rst` is high, `in_ready`=0. All other outputs are 0.
- Latency from the accept edge to `out_valid` high is 2 + n cycles: n=0 → 2, n=27 → 29. Special operands take 2 cycles.
- `out_valid` stays high until the `out_ready` cycle; the next operand accept comes no earlier than 1 cycle after that handshake.
- If `in_valid` and `out_ready` are both high while in DONE, only `out_ready` acts; the operand is accepted in the following IDLE cycle.
- `rst` in any state, including mid-SHIFT, discards the operation and returns to IDLE with reset values on the next edge.
- `exp_diff` saturates; for example, 254 − 1 is reported as 8'h7F.

## Structure
- Shared package/include `fp_pkg`:
  - `FRAC_W`, `EXP_W`, `MAX_SHIFT`.
  - Field positions: sign 31, exponent 30:23, fraction 22:0; GRS bit indices.
  - The FSM state encoding (IDLE, UNPACK, SHIFT, DONE).
  - The special exponent constant 8'hFF.
- One sub-module, `fp_unpack`, instantiated once per operand. It is combinational and produces sign, effective exponent, 27-bit fraction and the is_special flag.

## Test plan
- A=B=32'h3F800000 (1.0): `out_valid` 2 cycles after accept; `big_frac`=`small_frac`=27'h4000000, `exp_out`=127, `exp_diff`=0, `big_is_b`=0.
- A=32'h3F800000, B=32'h40000000 (2.0): latency 3; `big_is_b`=1, `exp_out`=128, `exp_diff`=8'hFF, `small_frac`=27'h2000000.
- A=32'h4B800000, B=32'h3F800001: n=24, latency 26; `small_frac`=27'h0000005 (guard set, fraction LSB folded into sticky).
- A=32'h7F000000, B=32'h3F800000: n capped at 27, latency 29; `exp_diff`=8'h7F, `small_frac`=27'h0000001.
- A=32'h7F800000 (Inf), B=1.0: `special`=1, latency 2, no shifting.
- Hold `out_ready`=0 for 5 cycles in DONE: outputs are stable and `in_ready`=0 throughout. Then assert `rst` mid-SHIFT of a new operation: next cycle IDLE, `out_valid`=0, all data outputs 0.
